// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / signed divide / signed remainder unit.
// Handshake: start is sampled in IDLE or DONE. busy is high while iterating.
// done pulses for one cycle with result and divByZero valid.
// Multiply is shift-add, one multiplier bit per cycle.
// Divide is restoring division on magnitudes, one quotient bit per cycle,
// with the sign fix applied on the last iteration.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divByZero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, stateNext;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] acc;
  logic             isRem, negQ, negR, zeroDiv;
  logic             accept, lastIter;
  logic [WIDTH-1:0] mulSum, magA, magB;
  logic [WIDTH:0]   remShift;
  logic             fits;
  logic [WIDTH-1:0] remNext, quoNext, qFinal, rFinal;

  assign lastIter = (cnt == CNTW'(WIDTH - 1));

  // Next-state selection; a request is accepted only from IDLE or DONE, multiply has priority
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (start && (isMul || isDiv || isMod)) begin
          accept    = 1'b1;
          stateNext = isMul ? MUL : DIV;
        end
      end
      MUL:     if (lastIter) stateNext = DONE;
      DIV:     if (zeroDiv || lastIter) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // One iteration of shift-add multiply and of restoring divide, plus the final sign fix
  always_comb begin
    mulSum   = acc + (regB[0] ? regA : '0);
    magA     = opA[WIDTH-1] ? -opA : opA;
    magB     = opB[WIDTH-1] ? -opB : opB;
    remShift = {acc, regA[WIDTH-1]};
    fits     = (remShift >= {1'b0, regB});
    remNext  = fits ? (remShift[WIDTH-1:0] - regB) : remShift[WIDTH-1:0];
    quoNext  = {regA[WIDTH-2:0], fits};
    qFinal   = negQ ? -quoNext : quoNext;
    rFinal   = negR ? -remNext : remNext;
  end

  // State, datapath registers and registered outputs.
  // During multiply: regA is the multiplicand, regB is the multiplier and acc is the partial sum.
  // During divide: regA holds the dividend/quotient, regB is the divisor and acc is the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      divByZero <= 1'b0;
      cnt       <= '0;
      regA      <= '0;
      regB      <= '0;
      acc       <= '0;
      isRem     <= 1'b0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      zeroDiv   <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext == MUL) || (stateNext == DIV);
      done  <= (stateNext == DONE);
      if (accept) begin
        cnt <= '0;
        acc <= '0;
        if (isMul) begin
          regA    <= opA;
          regB    <= opB;
          zeroDiv <= 1'b0;
        end else begin
          // A zero divisor keeps the raw dividend so that the remainder result can return it
          regA    <= (opB == '0) ? opA : magA;
          regB    <= magB;
          isRem   <= !isDiv;
          negQ    <= opA[WIDTH-1] ^ opB[WIDTH-1];
          negR    <= opA[WIDTH-1];
          zeroDiv <= (opB == '0);
        end
      end else if (state == MUL) begin
        acc  <= mulSum;
        regA <= {regA[WIDTH-2:0], 1'b0};
        regB <= {1'b0, regB[WIDTH-1:1]};
        cnt  <= cnt + CNTW'(1);
        if (lastIter) begin
          result    <= mulSum;
          divByZero <= 1'b0;
        end
      end else if (state == DIV) begin
        if (zeroDiv) begin
          result    <= isRem ? regA : '1;
          divByZero <= 1'b1;
        end else begin
          acc  <= remNext;
          regA <= quoNext;
          cnt  <= cnt + CNTW'(1);
          if (lastIter) begin
            result    <= isRem ? rFinal : qFinal;
            divByZero <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32.
// A cycle-level reference model derives the expected outputs from plain arithmetic.
// Directed operations also pin hand-computed results and latencies.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        isMul;
  logic        isDiv;
  logic        isMod;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        divByZero;

  int vecCount  = 0;
  int missCount = 0;
  bit checkEn   = 0;

  bit          mBusy     = 0;
  bit          mDone     = 0;
  bit          mDbz      = 0;
  logic [31:0] mResult   = '0;
  logic [31:0] pendRes   = '0;
  bit          pendDbz   = 0;
  int          remaining = 0;

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .isMul(isMul),
    .isDiv(isDiv),
    .isMod(isMod),
    .opA(opA),
    .opB(opB),
    .busy(busy),
    .done(done),
    .result(result),
    .divByZero(divByZero)
  );

  // Free-running clock with a 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: returns {divByZero, result} for one operation
  function automatic logic [32:0] modelOp(input bit m, input bit d,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    if (m) begin
      p = {32'b0, a} * {32'b0, b};
      return {1'b0, p[31:0]};
    end else if (b == 32'h0) begin
      return {1'b1, d ? 32'hFFFF_FFFF : a};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {1'b0, d ? 32'h8000_0000 : 32'h0};
    end else begin
      sa = a;
      sb = b;
      return {1'b0, d ? 32'(sa / sb) : 32'(sa % sb)};
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request starting just after a rising edge, then release the request after the accepting edge.
  // The operands are scrambled afterwards so that any failure to latch them shows up.
  task automatic applyStimulus(input bit m, input bit d, input bit md,
                               input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    isMul = m;
    isDiv = d;
    isMod = md;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #2;
    start = 1'b0;
    isMul = 1'b0;
    isDiv = 1'b0;
    isMod = 1'b0;
    opA   = 32'hDEAD_BEEF;
    opB   = 32'h0BAD_F00D;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic runOp(input string name, input bit m, input bit d, input bit md,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input bit expDbz, input int expEdges);
    int edges;
    applyStimulus(m, d, md, a, b);
    waitDone(edges);
    checkOutput({name, "_latency"}, 32'(edges), 32'(expEdges));
    checkOutput({name, "_result"}, result, expRes);
    checkOutput({name, "_dbz"}, 32'(divByZero), 32'(expDbz));
  endtask

  // Reference timing model: accept when idle, count down the iterations, then publish the result for one cycle
  always @(posedge clk) begin
    if (rst) begin
      mBusy     = 0;
      mDone     = 0;
      mDbz      = 0;
      mResult   = '0;
      remaining = 0;
    end else if (mBusy) begin
      remaining--;
      if (remaining == 0) begin
        mBusy   = 0;
        mDone   = 1;
        mResult = pendRes;
        mDbz    = pendDbz;
      end
    end else begin
      mDone = 0;
      if (start && (isMul || isDiv || isMod)) begin
        {pendDbz, pendRes} = modelOp(isMul, !isMul && isDiv, opA, opB);
        remaining = (!isMul && opB == 32'h0) ? 1 : WIDTH;
        mBusy = 1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_busy", 32'(busy), 32'(mBusy));
      checkOutput("cyc_done", 32'(done), 32'(mDone));
      checkOutput("cyc_result", result, mResult);
      checkOutput("cyc_dbz", 32'(divByZero), 32'(mDbz));
    end
  end

  // Give up with a failure if the directed sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Directed sequence
  initial begin
    int  edges;
    bit  sawDone;
    rst   = 1'b1;
    start = 1'b0;
    isMul = 1'b0;
    isDiv = 1'b0;
    isMod = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_dbz", 32'(divByZero), 32'h0);
    #1;
    rst     = 1'b0;
    checkEn = 1'b1;

    runOp("mul_7x-3", 1, 0, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 32);
    runOp("div_-7/2", 0, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 32);
    runOp("mod_-7%2", 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 32);
    runOp("mod_7%-2", 0, 0, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 32);
    @(posedge clk);
    #2;
    runOp("div_5/0", 0, 1, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
    runOp("mod_5%0", 0, 0, 1, 32'd5, 32'd0, 32'd5, 1, 1);
    runOp("div_100/7", 0, 1, 0, 32'd100, 32'd7, 32'd14, 0, 32);
    runOp("mod_100%7", 0, 0, 1, 32'd100, 32'd7, 32'd2, 0, 32);
    runOp("div_-100/-7", 0, 1, 0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0, 32);
    runOp("mod_-100%-7", 0, 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 32);
    runOp("div_min/-1", 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32);
    runOp("mod_min%-1", 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 32);
    runOp("mul_ffff", 1, 0, 0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0, 32);
    runOp("mul_-1x-1", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 32);
    @(posedge clk);
    #2;

    // A start request with no operation flag must be ignored
    applyStimulus(0, 0, 0, 32'd5, 32'd5);
    checkOutput("noflag_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("noflag_done", 32'(done), 32'h0);
    #1;

    // A start issued in the middle of a multiply must not disturb it
    applyStimulus(1, 0, 0, 32'd6, 32'd9);
    repeat (10) @(posedge clk);
    #2;
    applyStimulus(0, 1, 0, 32'd1, 32'd1);
    waitDone(edges);
    checkOutput("midstart_latency", 32'(edges + 11), 32'd32);
    checkOutput("midstart_result", result, 32'd54);
    // A start on the done cycle is accepted back to back
    runOp("b2b_mul_3x5", 1, 0, 0, 32'd3, 32'd5, 32'd15, 0, 32);
    @(posedge clk);
    #2;

    runOp("prio_mul_div", 1, 1, 0, 32'd6, 32'd3, 32'd18, 0, 32);
    runOp("prio_div_mod", 0, 1, 1, 32'd7, 32'd2, 32'd3, 0, 32);
    @(posedge clk);
    #2;

    // Reset in the middle of a divide aborts it without a done pulse
    applyStimulus(0, 1, 0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    checkOutput("abort_result", result, 32'h0);
    #1;
    rst = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'h0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
